// File: rtl/streaming_dwc_pkg.sv
// streaming_dwc_pkg: shared types and elaboration-time helpers for the
// streaming data-width converter (mode selection, ratio and index width).
package streaming_dwc_pkg;

  typedef enum logic [1:0] {
    DWC_DOWN = 2'd0,
    DWC_UP   = 2'd1,
    DWC_EQ   = 2'd2
  } dwc_mode_e;

  // Ratio between the wider and the narrower side.
  function automatic int dwc_k(input int in_w, input int out_w);
    if (in_w >= out_w) begin
      return in_w / out_w;
    end else begin
      return out_w / in_w;
    end
  endfunction

  // Width of the slice index; never narrower than one bit.
  function automatic int dwc_idx_width(input int k);
    if (k <= 2) begin
      return 1;
    end else begin
      return $clog2(k);
    end
  endfunction

  // Which datapath the top generates for a given width pair.
  function automatic dwc_mode_e dwc_mode(input int in_w, input int out_w);
    if (in_w > out_w) begin
      return DWC_DOWN;
    end else if (in_w < out_w) begin
      return DWC_UP;
    end else begin
      return DWC_EQ;
    end
  endfunction

  // Widths are legal only when one is an exact multiple of the other.
  function automatic bit dwc_widths_ok(input int in_w, input int out_w);
    if (in_w <= 0 || out_w <= 0) begin
      return 1'b0;
    end else begin
      return ((in_w % out_w) == 0) || ((out_w % in_w) == 0);
    end
  endfunction

endpackage

// File: rtl/streaming_dwc_if.sv
// streaming_dwc_if: one AXI-Stream channel (TDATA/TVALID/TREADY).
// master drives data/valid, slave drives ready.
interface streaming_dwc_if #(
  parameter int W = 32
) ();
  logic [W-1:0] TDATA;
  logic         TVALID;
  logic         TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/dwc_slice_counter.sv
// dwc_slice_counter: wrapping 0..K-1 slice index with enable; last flags K-1.
module dwc_slice_counter #(
  parameter int K     = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  assign last = (idx == IDX_W'(K - 1));

  // Advance the slice index on each enabled cycle, wrapping after K-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= {IDX_W{1'b0}};
    end else if (en) begin
      if (last) begin
        idx <= {IDX_W{1'b0}};
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/streaming_dwc.sv
// streaming_dwc: AXI-Stream data-width converter. Splits wide words into
// LSB-first slices (down), packs narrow words LSB-first (up), or acts as a
// single register slice (equal widths).
// Optional feature macro: STREAMING_DWC_STATS_EN adds count_out, a 32-bit
// wrapping count of output handshakes.
module streaming_dwc
  import streaming_dwc_pkg::*;
#(
  parameter int IN_WIDTH  = 96,
  parameter int OUT_WIDTH = 32
) (
  input  logic            ap_clk,
  input  logic            ap_rst,
  streaming_dwc_if.slave  in0_V_V,
  streaming_dwc_if.master out_V_V
`ifdef STREAMING_DWC_STATS_EN
  ,
  output logic [31:0]     count_out
`endif
);

  localparam dwc_mode_e MODE  = dwc_mode(IN_WIDTH, OUT_WIDTH);
  localparam int        K     = dwc_k(IN_WIDTH, OUT_WIDTH);
  localparam int        IDX_W = dwc_idx_width(K);

  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 in_hs;
  logic                 out_hs;

  // in_ready depends only on state and out TREADY, never on in TVALID.
  assign in_hs          = in0_V_V.TVALID && in_ready;
  assign out_hs         = out_valid && out_V_V.TREADY;
  assign in0_V_V.TREADY = in_ready;
  assign out_V_V.TVALID = out_valid;
  assign out_V_V.TDATA  = out_data;

  if (!dwc_widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_widths
    $error("streaming_dwc: IN_WIDTH and OUT_WIDTH must be integer multiples");
  end

  case (MODE)
    DWC_DOWN: begin : g_down
      logic [IN_WIDTH-1:0] hold;
      logic                full;
      logic [IDX_W-1:0]    idx;
      logic                last;

      dwc_slice_counter #(.K(K), .IDX_W(IDX_W)) u_cnt (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .en   (out_hs),
        .idx  (idx),
        .last (last)
      );

      // Accept a new word while the last slice leaves, so there is no bubble.
      assign in_ready  = !ap_rst && (!full || (out_V_V.TREADY && last));
      assign out_valid = full;
      assign out_data  = hold[32'(idx) * 32'(OUT_WIDTH) +: OUT_WIDTH];

      // Load on accept; drain after the last slice unless refilled the same cycle.
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          hold <= {IN_WIDTH{1'b0}};
          full <= 1'b0;
        end else if (out_hs && last) begin
          full <= in_hs;
          if (in_hs) begin
            hold <= in0_V_V.TDATA;
          end
        end else if (in_hs) begin
          hold <= in0_V_V.TDATA;
          full <= 1'b1;
        end
      end
    end

    DWC_UP: begin : g_up
      logic [OUT_WIDTH-1:0] hold;
      logic                 full;
      logic [IDX_W-1:0]     idx;
      logic                 last;

      dwc_slice_counter #(.K(K), .IDX_W(IDX_W)) u_cnt (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .en   (in_hs),
        .idx  (idx),
        .last (last)
      );

      // While full, idx is 0: slice 0 of the next word may land as the word leaves.
      assign in_ready  = !ap_rst && (!full || out_V_V.TREADY);
      assign out_valid = full;
      assign out_data  = hold;

      // Pack each accepted narrow word into its slot; the K-th write completes the word.
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          hold <= {OUT_WIDTH{1'b0}};
          full <= 1'b0;
        end else begin
          if (in_hs) begin
            hold[32'(idx) * 32'(IN_WIDTH) +: IN_WIDTH] <= in0_V_V.TDATA;
          end
          if (in_hs && last) begin
            full <= 1'b1;
          end else if (out_hs) begin
            full <= 1'b0;
          end
        end
      end
    end

    default: begin : g_eq
      logic [OUT_WIDTH-1:0] hold;
      logic                 full;

      assign in_ready  = !ap_rst && (!full || out_V_V.TREADY);
      assign out_valid = full;
      assign out_data  = hold;

      // Single register slice: capture on accept, empty when drained without refill.
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          hold <= {OUT_WIDTH{1'b0}};
          full <= 1'b0;
        end else if (in_hs) begin
          hold <= in0_V_V.TDATA;
          full <= 1'b1;
        end else if (out_hs) begin
          full <= 1'b0;
        end
      end
    end
  endcase

`ifdef STREAMING_DWC_STATS_EN
  // Count output handshakes; wraps from 2^32-1 to 0.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      count_out <= 32'd0;
    end else if (out_hs) begin
      count_out <= count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_streaming_dwc.sv
// tb_streaming_dwc: directed and randomized-handshake checks of streaming_dwc
// in 96->32 (down), 32->96 (up) and 32->32 (equal) configurations.
module tb_streaming_dwc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  streaming_dwc_if #(.W(96)) dn_in  ();
  streaming_dwc_if #(.W(32)) dn_out ();
  streaming_dwc_if #(.W(32)) up_in  ();
  streaming_dwc_if #(.W(96)) up_out ();
  streaming_dwc_if #(.W(32)) eq_in  ();
  streaming_dwc_if #(.W(32)) eq_out ();

`ifdef STREAMING_DWC_STATS_EN
  logic [31:0] dn_count;
  logic [31:0] up_count;
  logic [31:0] eq_count;
`endif

  streaming_dwc #(.IN_WIDTH(96), .OUT_WIDTH(32)) u_dn (
    .ap_clk(clk), .ap_rst(rst), .in0_V_V(dn_in), .out_V_V(dn_out)
`ifdef STREAMING_DWC_STATS_EN
    , .count_out(dn_count)
`endif
  );

  streaming_dwc #(.IN_WIDTH(32), .OUT_WIDTH(96)) u_up (
    .ap_clk(clk), .ap_rst(rst), .in0_V_V(up_in), .out_V_V(up_out)
`ifdef STREAMING_DWC_STATS_EN
    , .count_out(up_count)
`endif
  );

  streaming_dwc #(.IN_WIDTH(32), .OUT_WIDTH(32)) u_eq (
    .ap_clk(clk), .ap_rst(rst), .in0_V_V(eq_in), .out_V_V(eq_out)
`ifdef STREAMING_DWC_STATS_EN
    , .count_out(eq_count)
`endif
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (dn_out.TVALID !== 1'b0) begin bad++; $display("FAIL rst_dn_valid got=%b want=0", dn_out.TVALID); end
    total++; if (dn_in.TREADY !== 1'b0) begin bad++; $display("FAIL rst_dn_ready got=%b want=0", dn_in.TREADY); end
    total++; if (up_out.TVALID !== 1'b0) begin bad++; $display("FAIL rst_up_valid got=%b want=0", up_out.TVALID); end
    total++; if (up_in.TREADY !== 1'b0) begin bad++; $display("FAIL rst_up_ready got=%b want=0", up_in.TREADY); end
    total++; if (eq_in.TREADY !== 1'b0) begin bad++; $display("FAIL rst_eq_ready got=%b want=0", eq_in.TREADY); end
    rst = 1'b0;
    #1;
    total++; if (dn_in.TREADY !== 1'b1) begin bad++; $display("FAIL rst_release_dn_ready got=%b want=1", dn_in.TREADY); end
    total++; if (dn_out.TVALID !== 1'b0) begin bad++; $display("FAIL rst_release_dn_valid got=%b want=0", dn_out.TVALID); end
  endtask

  task automatic test_down_basic;
    logic [31:0] exp_s [3];
    exp_s = '{32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    @(negedge clk);
    dn_out.TREADY = 1'b1;
    dn_in.TDATA   = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC;
    dn_in.TVALID  = 1'b1;
    #1;
    total++; if (dn_in.TREADY !== 1'b1) begin bad++; $display("FAIL dn_accept got=%b want=1", dn_in.TREADY); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dn_in.TVALID = 1'b0;
      #1;
      total++; if (dn_out.TVALID !== 1'b1) begin bad++; $display("FAIL dn_valid[%0d] got=%b want=1", i, dn_out.TVALID); end
      total++; if (dn_out.TDATA !== exp_s[i]) begin bad++; $display("FAIL dn_slice[%0d] got=%h want=%h", i, dn_out.TDATA, exp_s[i]); end
      total++; if (dn_in.TREADY !== (i == 2)) begin bad++; $display("FAIL dn_ready[%0d] got=%b want=%b", i, dn_in.TREADY, (i == 2)); end
    end
    @(negedge clk);
    #1;
    total++; if (dn_out.TVALID !== 1'b0) begin bad++; $display("FAIL dn_drained got=%b want=0", dn_out.TVALID); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] sl [12];
    int widx = 0;
    int oidx = 0;
    int gaps = 0;
    int cyc  = 0;
    bit started = 1'b0;
    sl = '{32'h10000000, 32'h10000001, 32'h10000002,
           32'h20000000, 32'h20000001, 32'h20000002,
           32'h30000000, 32'h30000001, 32'h30000002,
           32'h40000000, 32'h40000001, 32'h40000002};
    @(negedge clk);
    dn_out.TREADY = 1'b1;
    dn_in.TDATA   = {sl[2], sl[1], sl[0]};
    dn_in.TVALID  = 1'b1;
    while (oidx < 12 && cyc < 100) begin
      #1;
      if (dn_in.TVALID && dn_in.TREADY) widx++;
      if (dn_out.TVALID) begin
        total++;
        if (dn_out.TDATA !== sl[oidx]) begin bad++; $display("FAIL b2b_slice[%0d] got=%h want=%h", oidx, dn_out.TDATA, sl[oidx]); end
        oidx++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      @(negedge clk);
      cyc++;
      if (widx < 4) begin
        dn_in.TDATA = {sl[3*widx+2], sl[3*widx+1], sl[3*widx]};
      end else begin
        dn_in.TVALID = 1'b0;
      end
    end
    dn_in.TVALID = 1'b0;
    total++; if (gaps != 0) begin bad++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    total++; if (oidx != 12) begin bad++; $display("FAIL b2b_count got=%0d want=12", oidx); end
  endtask

  task automatic test_up_basic;
    logic [95:0] exp_w;
    exp_w = 96'h00000003_00000002_00000001;
    @(negedge clk);
    up_out.TREADY = 1'b0;
    up_in.TDATA   = 32'h1;
    up_in.TVALID  = 1'b1;
    #1;
    total++; if (up_in.TREADY !== 1'b1) begin bad++; $display("FAIL up_accept got=%b want=1", up_in.TREADY); end
    @(negedge clk);
    up_in.TDATA = 32'h2;
    #1;
    total++; if (up_out.TVALID !== 1'b0) begin bad++; $display("FAIL up_early1 got=%b want=0", up_out.TVALID); end
    @(negedge clk);
    up_in.TDATA = 32'h3;
    #1;
    total++; if (up_out.TVALID !== 1'b0) begin bad++; $display("FAIL up_early2 got=%b want=0", up_out.TVALID); end
    @(negedge clk);
    up_in.TVALID = 1'b0;
    #1;
    total++; if (up_out.TVALID !== 1'b1) begin bad++; $display("FAIL up_valid got=%b want=1", up_out.TVALID); end
    total++; if (up_out.TDATA !== exp_w) begin bad++; $display("FAIL up_word got=%h want=%h", up_out.TDATA, exp_w); end
    total++; if (up_in.TREADY !== 1'b0) begin bad++; $display("FAIL up_stall_ready got=%b want=0", up_in.TREADY); end
    up_in.TDATA  = 32'h4;
    up_in.TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++; if (up_out.TVALID !== 1'b1 || up_out.TDATA !== exp_w) begin bad++; $display("FAIL up_hold[%0d] got=%b/%h want=1/%h", i, up_out.TVALID, up_out.TDATA, exp_w); end
      total++; if (up_in.TREADY !== 1'b0) begin bad++; $display("FAIL up_hold_ready[%0d] got=%b want=0", i, up_in.TREADY); end
    end
    @(negedge clk);
    up_out.TREADY = 1'b1;
    #1;
    total++; if (up_in.TREADY !== 1'b1) begin bad++; $display("FAIL up_release_ready got=%b want=1", up_in.TREADY); end
    @(negedge clk);
    #1;
    total++; if (up_out.TVALID !== 1'b0) begin bad++; $display("FAIL up_after_drain got=%b want=0", up_out.TVALID); end
    up_in.TDATA = 32'h5;
    @(negedge clk);
    up_in.TDATA = 32'h6;
    @(negedge clk);
    up_in.TVALID = 1'b0;
    #1;
    total++; if (up_out.TVALID !== 1'b1 || up_out.TDATA !== 96'h00000006_00000005_00000004) begin bad++; $display("FAIL up_overlap_word got=%b/%h want=1/000000060000000500000004", up_out.TVALID, up_out.TDATA); end
    @(negedge clk);
    #1;
    total++; if (up_out.TVALID !== 1'b0) begin bad++; $display("FAIL up_final_drain got=%b want=0", up_out.TVALID); end
  endtask

  task automatic test_equal;
    @(negedge clk);
    eq_out.TREADY = 1'b1;
    eq_in.TDATA   = 32'hDEAD0001;
    eq_in.TVALID  = 1'b1;
    #1;
    total++; if (eq_in.TREADY !== 1'b1) begin bad++; $display("FAIL eq_accept got=%b want=1", eq_in.TREADY); end
    @(negedge clk);
    eq_in.TDATA = 32'hDEAD0002;
    #1;
    total++; if (eq_out.TVALID !== 1'b1 || eq_out.TDATA !== 32'hDEAD0001) begin bad++; $display("FAIL eq_w1 got=%b/%h want=1/dead0001", eq_out.TVALID, eq_out.TDATA); end
    @(negedge clk);
    eq_in.TDATA = 32'hDEAD0003;
    #1;
    total++; if (eq_out.TVALID !== 1'b1 || eq_out.TDATA !== 32'hDEAD0002) begin bad++; $display("FAIL eq_w2 got=%b/%h want=1/dead0002", eq_out.TVALID, eq_out.TDATA); end
    @(negedge clk);
    eq_in.TVALID  = 1'b0;
    eq_out.TREADY = 1'b0;
    #1;
    total++; if (eq_out.TDATA !== 32'hDEAD0003) begin bad++; $display("FAIL eq_w3 got=%h want=dead0003", eq_out.TDATA); end
    total++; if (eq_in.TREADY !== 1'b0) begin bad++; $display("FAIL eq_stall_ready got=%b want=0", eq_in.TREADY); end
    @(negedge clk);
    #1;
    total++; if (eq_out.TVALID !== 1'b1 || eq_out.TDATA !== 32'hDEAD0003) begin bad++; $display("FAIL eq_hold got=%b/%h want=1/dead0003", eq_out.TVALID, eq_out.TDATA); end
    eq_out.TREADY = 1'b1;
    @(negedge clk);
    #1;
    total++; if (eq_out.TVALID !== 1'b0) begin bad++; $display("FAIL eq_drain got=%b want=0", eq_out.TVALID); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_s [3];
    exp_s = '{32'h44444444, 32'h55555555, 32'h66666666};
    @(negedge clk);
    dn_out.TREADY = 1'b1;
    dn_in.TDATA   = 96'h33333333_22222222_11111111;
    dn_in.TVALID  = 1'b1;
    @(negedge clk);
    dn_in.TVALID = 1'b0;
    #1;
    total++; if (dn_out.TDATA !== 32'h11111111) begin bad++; $display("FAIL rmid_slice0 got=%h want=11111111", dn_out.TDATA); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (dn_out.TVALID !== 1'b0) begin bad++; $display("FAIL rmid_valid_async got=%b want=0", dn_out.TVALID); end
    total++; if (dn_in.TREADY !== 1'b0) begin bad++; $display("FAIL rmid_ready_async got=%b want=0", dn_in.TREADY); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      total++; if (dn_out.TVALID !== 1'b0) begin bad++; $display("FAIL rmid_idle[%0d] got=%b want=0", i, dn_out.TVALID); end
    end
    @(negedge clk);
    dn_in.TDATA  = 96'h66666666_55555555_44444444;
    dn_in.TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dn_in.TVALID = 1'b0;
      #1;
      total++; if (dn_out.TVALID !== 1'b1 || dn_out.TDATA !== exp_s[i]) begin bad++; $display("FAIL rmid_new[%0d] got=%b/%h want=1/%h", i, dn_out.TVALID, dn_out.TDATA, exp_s[i]); end
    end
    @(negedge clk);
    #1;
    total++; if (dn_out.TVALID !== 1'b0) begin bad++; $display("FAIL rmid_drain got=%b want=0", dn_out.TVALID); end
  endtask

  task automatic test_random_down;
    logic [31:0] q [$];
    logic [31:0] exp_v;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit acc  = 1'b0;
    dn_in.TVALID = 1'b0;
    while (got < 3000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (acc) dn_in.TVALID = 1'b0;
      acc = 1'b0;
      if (!dn_in.TVALID && sent < 1000 && $urandom_range(0, 1) == 1) begin
        dn_in.TDATA  = {$urandom, $urandom, $urandom};
        dn_in.TVALID = 1'b1;
      end
      dn_out.TREADY = 1'($urandom_range(0, 1));
      #1;
      if (dn_in.TVALID && dn_in.TREADY) begin
        q.push_back(dn_in.TDATA[31:0]);
        q.push_back(dn_in.TDATA[63:32]);
        q.push_back(dn_in.TDATA[95:64]);
        sent++;
        acc = 1'b1;
      end
      if (dn_out.TVALID && dn_out.TREADY) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_dn_extra got=%h want=none", dn_out.TDATA);
        end else begin
          exp_v = q.pop_front();
          if (dn_out.TDATA !== exp_v) begin bad++; $display("FAIL rand_dn_slice[%0d] got=%h want=%h", got, dn_out.TDATA, exp_v); end
        end
        got++;
      end
    end
    @(negedge clk);
    dn_in.TVALID  = 1'b0;
    dn_out.TREADY = 1'b1;
    total++; if (got != 3000 || q.size() != 0) begin bad++; $display("FAIL rand_dn_done got=%0d left=%0d want=3000/0", got, q.size()); end
  endtask

  task automatic test_random_up;
    logic [95:0] q [$];
    logic [95:0] exp_v;
    logic [95:0] acc_w;
    int part = 0;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit acc  = 1'b0;
    acc_w = 96'h0;
    up_in.TVALID = 1'b0;
    while (got < 334 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (acc) up_in.TVALID = 1'b0;
      acc = 1'b0;
      if (!up_in.TVALID && sent < 1002 && $urandom_range(0, 1) == 1) begin
        up_in.TDATA  = $urandom;
        up_in.TVALID = 1'b1;
      end
      up_out.TREADY = 1'($urandom_range(0, 1));
      #1;
      if (up_in.TVALID && up_in.TREADY) begin
        acc_w[part*32 +: 32] = up_in.TDATA;
        part++;
        if (part == 3) begin
          q.push_back(acc_w);
          part = 0;
        end
        sent++;
        acc = 1'b1;
      end
      if (up_out.TVALID && up_out.TREADY) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_up_extra got=%h want=none", up_out.TDATA);
        end else begin
          exp_v = q.pop_front();
          if (up_out.TDATA !== exp_v) begin bad++; $display("FAIL rand_up_word[%0d] got=%h want=%h", got, up_out.TDATA, exp_v); end
        end
        got++;
      end
    end
    @(negedge clk);
    up_in.TVALID  = 1'b0;
    up_out.TREADY = 1'b1;
    total++; if (got != 334 || q.size() != 0) begin bad++; $display("FAIL rand_up_done got=%0d left=%0d want=334/0", got, q.size()); end
  endtask

`ifdef STREAMING_DWC_STATS_EN
  task automatic test_stats;
    int n   = 0;
    int cyc = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (dn_count !== 32'd0) begin bad++; $display("FAIL stats_reset got=%h want=0", dn_count); end
    dn_out.TREADY = 1'b1;
    dn_in.TDATA   = 96'h0000000C_0000000B_0000000A;
    dn_in.TVALID  = 1'b1;
    while (n < 5 && cyc < 100) begin
      #1;
      if (dn_in.TVALID && dn_in.TREADY) n++;
      @(negedge clk);
      cyc++;
      if (n == 5) dn_in.TVALID = 1'b0;
    end
    dn_in.TVALID = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (dn_count !== 32'd15) begin bad++; $display("FAIL stats_count15 got=%0d want=15", dn_count); end
    force u_dn.count_out = 32'hFFFFFFFE;
    @(negedge clk);
    release u_dn.count_out;
    dn_in.TVALID = 1'b1;
    @(negedge clk);
    dn_in.TVALID = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (dn_count !== 32'd0) begin bad++; $display("FAIL stats_wrap got=%h want=00000000", dn_count); end
    @(negedge clk);
    #1;
    total++; if (dn_count !== 32'd1) begin bad++; $display("FAIL stats_after_wrap got=%h want=00000001", dn_count); end
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dn_in.TDATA = 96'h0;  dn_in.TVALID = 1'b0;  dn_out.TREADY = 1'b0;
    up_in.TDATA = 32'h0;  up_in.TVALID = 1'b0;  up_out.TREADY = 1'b0;
    eq_in.TDATA = 32'h0;  eq_in.TVALID = 1'b0;  eq_out.TREADY = 1'b0;
    test_reset();
    test_down_basic();
    test_back_to_back();
    test_up_basic();
    test_equal();
    test_reset_mid();
    test_random_down();
    test_random_up();
`ifdef STREAMING_DWC_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
